// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage iterative divider.
package ex_div_pkg;

  localparam int unsigned DivWidth  = 32;
  localparam int unsigned DivCntBus = $clog2(DivWidth) + 1;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivCalc = 2'd1,
    DivDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module ex_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             quot_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    shifted  = {rem_in, dvd_bit};
    borrow   = shifted < {1'b0, dvs};
    // On success the difference is below dvs, so the low WIDTH bits are exact.
    diff     = shifted[WIDTH-1:0] - dvs;
    quot_bit = ~borrow;
    rem_out  = borrow ? shifted[WIDTH-1:0] : diff;
  end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit with pipeline stall request.
// Define EX_DIV_FASTPATH_EN to resolve divide-by-zero and signed overflow in one cycle.
module ex_div_unit
  import ex_div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic             div_rem,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             stallreq_ex
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  div_state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, quot_q, rem_q, orig_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rem_sel_q, dvd_neg_q, quot_neg_q, dvs_zero_q;

  logic             start;
  logic             dvd_neg, dvs_neg, dvs_zero_in;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quot_fin, quot_out, rem_out, calc_result;

  assign start       = div_start & ~flush;
  assign dvd_neg     = div_signed & dividend[WIDTH-1];
  assign dvs_neg     = div_signed & divisor[WIDTH-1];
  assign dvd_abs     = dvd_neg ? -dividend : dividend;
  assign dvs_abs     = dvs_neg ? -divisor : divisor;
  assign dvs_zero_in = (divisor == '0);

`ifdef EX_DIV_FASTPATH_EN
  logic             ovf_in;
  logic [WIDTH-1:0] special_result;

  assign ovf_in = div_signed & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (divisor == '1);
  always_comb begin
    if (dvs_zero_in) begin
      special_result = div_rem ? dividend : '1;
    end else begin
      special_result = div_rem ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`endif

  ex_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .quot_bit(step_q)
  );

  // Final result is formed from the last step so it can be registered on entry to DONE.
  always_comb begin
    quot_fin = {quot_q[WIDTH-2:0], step_q};
    if (dvs_zero_q) begin
      quot_out = '1;
      rem_out  = orig_q;
    end else begin
      quot_out = quot_neg_q ? -quot_fin : quot_fin;
      rem_out  = dvd_neg_q ? -step_rem : step_rem;
    end
    calc_result = rem_sel_q ? rem_out : quot_out;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      DivIdle: begin
        if (start) begin
          state_d = DivCalc;
`ifdef EX_DIV_FASTPATH_EN
          if (dvs_zero_in || ovf_in) begin
            state_d  = DivDone;
            result_d = special_result;
          end
`endif
        end
      end
      DivCalc: begin
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = DivDone;
          result_d = calc_result;
        end
      end
      DivDone: state_d = DivIdle;
      default: state_d = DivIdle;
    endcase
    if (flush) begin
      state_d  = DivIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivIdle;
      result_q   <= '0;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      orig_q     <= '0;
      rem_sel_q  <= 1'b0;
      dvd_neg_q  <= 1'b0;
      quot_neg_q <= 1'b0;
      dvs_zero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (state_q == DivIdle && start) begin
        rem_sel_q  <= div_rem;
        orig_q     <= dividend;
        dvd_q      <= dvd_abs;
        dvs_q      <= dvs_abs;
        dvd_neg_q  <= dvd_neg;
        quot_neg_q <= dvd_neg ^ dvs_neg;
        dvs_zero_q <= dvs_zero_in;
        quot_q     <= '0;
        rem_q      <= '0;
        cnt_q      <= '0;
      end else if (state_q == DivCalc) begin
        rem_q  <= step_rem;
        quot_q <= quot_fin;
        dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
        cnt_q  <= cnt_q + CntW'(1);
      end
    end
  end

  assign ready       = (state_q == DivDone) & ~flush;
  assign result      = result_q;
  assign stallreq_ex = div_start & ~ready;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit with a RISC-V division reference model.
module tb_ex_div_unit;

`ifdef EX_DIV_FASTPATH_EN
  localparam int SpecLat = 1;
`else
  localparam int SpecLat = 33;
`endif
  localparam int FullLat = 33;

  logic        clk = 1'b0;
  logic        rst, flush, div_start, div_signed, div_rem;
  logic [31:0] dividend, divisor, result;
  logic        ready, stallreq_ex;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic        armed = 1'b0;
  logic [31:0] exp_result = '0;

  always #5 clk = ~clk;

  ex_div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_rem    (div_rem),
    .dividend   (dividend),
    .divisor    (divisor),
    .result     (result),
    .ready      (ready),
    .stallreq_ex(stallreq_ex)
  );

  function automatic logic [31:0] model(input logic sgn, input logic rm,
                                        input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'd0 : 32'h8000_0000;
      return rm ? 32'(sa % sb) : 32'(sa / sb);
    end
    return rm ? a % b : a / b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Every cycle: stall must follow div_start & ~ready; any ready must carry the model result.
  always @(negedge clk) begin
    if (rst !== 1'b1 || ready !== 1'b0) begin
      n_cmp++;
      if (stallreq_ex !== (div_start & ~ready)) begin
        n_fail++;
        $display("FAIL stall_rule: got %b, expected %b", stallreq_ex, div_start & ~ready);
      end
    end
    if (ready === 1'b1) begin
      n_cmp++;
      if (!armed) begin
        n_fail++;
        $display("FAIL spurious_ready: got ready=1, expected ready=0 (result 0x%08h)", result);
      end else if (result !== exp_result) begin
        n_fail++;
        $display("FAIL result: got 0x%08h, expected 0x%08h", result, exp_result);
      end
    end
  end

  // Call just after a rising edge; that cycle becomes cycle 0 of the op.
  task automatic start_op(input logic sgn, input logic rm, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit);
    div_signed = sgn;
    div_rem    = rm;
    dividend   = a;
    divisor    = b;
    div_start  = 1'b1;
    exp_result = model(sgn, rm, a, b);
    chk("model_vs_hand", exp_result, lit);
    armed = 1'b1;
  endtask

  task automatic wait_ready(input string name, input int lat);
    int k;
    int stalls;
    bit seen;
    k      = 0;
    stalls = 0;
    seen   = 0;
    while (k < 40 && !seen) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        seen = 1;
      end else begin
        if (stallreq_ex === 1'b1) stalls++;
        // Operands must be ignored once the divide is under way.
        if (k == 2) begin
          dividend = ~dividend;
          divisor  = divisor + 32'd1;
        end
        k++;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got no ready in 40 cycles, expected ready at cycle %0d",
               name, lat);
    end else begin
      chk({name, "_latency"}, 32'(k), 32'(lat));
      chk({name, "_stall_cycles"}, 32'(stalls), 32'(lat));
    end
    @(posedge clk);
    #1;
    div_start = 1'b0;
    armed     = 1'b0;
  endtask

  task automatic run_op(input string name, input logic sgn, input logic rm,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input int lat);
    @(posedge clk);
    #1;
    start_op(sgn, rm, a, b, lit);
    wait_ready(name, lat);
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_rem    = 1'b0;
    dividend   = '0;
    divisor    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_stall_idle", {31'd0, stallreq_ex}, 32'd0);
    div_start = 1'b1;
    #1;
    chk("reset_stall_start", {31'd0, stallreq_ex}, 32'd1);
    div_start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op("divu_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, FullLat);
    run_op("remu_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, FullLat);
    run_op("div_m7_2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FullLat);
    run_op("rem_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FullLat);
    run_op("div_7_m2", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, FullLat);
    run_op("rem_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, FullLat);
    run_op("div_m5_0", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SpecLat);
    run_op("rem_m5_0", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SpecLat);
    run_op("divu_x_0", 1'b0, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, SpecLat);
    run_op("div_ovf", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SpecLat);
    run_op("rem_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SpecLat);
    run_op("divu_big", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, FullLat);
    run_op("divu_max_1", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, FullLat);
    run_op("remu_max_16", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd16, 32'd15, FullLat);

    // Flush at cycle 10: no ready for the cancelled op, new op sampled at cycle 11.
    @(posedge clk);
    #1;
    start_op(1'b0, 1'b0, 32'd100, 32'd7, 32'd14);
    armed = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start_op(1'b0, 1'b0, 32'd9, 32'd3, 32'd3);
    wait_ready("flush_then_divu", FullLat);

    // Reset at cycle 20 with div_start held: result clears and the op restarts.
    @(posedge clk);
    #1;
    start_op(1'b0, 1'b0, 32'd100, 32'd7, 32'd14);
    armed = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_ready", {31'd0, ready}, 32'd0);
    armed = 1'b1;
    wait_ready("rst_restart", FullLat);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative 32-bit integer divider in the EX stage, executing DIV/DIVU/REM/REMU with RISC-V M-extension results. While a division is in flight it raises `stallreq_ex` to the pipeline controller, which freezes the stages up to and including EX. It drops the request in the cycle the result is ready, so the instruction retires from EX with a valid `result`.

## Interface
- `WIDTH`, 32: operand/result width; counter width is clog2(WIDTH)+1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  pipeline flush; cancels any in-flight division.
- `div_start`  in  1  level; EX holds a divide op; held high while stalled.
- `div_signed`  in  1  1 = DIV/REM, 0 = DIVU/REMU.
- `div_rem`  in  1  1 = return remainder, 0 = quotient.
- `dividend`  in  WIDTH  rs1 value.
- `divisor`  in  WIDTH  rs2 value.
- `result`  out  WIDTH  quotient or remainder; valid only while `ready`=1.
- `ready`  out  1  one-cycle pulse; result valid.
- `stallreq_ex`  out  1  combinational: `div_start & ~ready`.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - If `div_start` & ~`flush`: latch `div_signed`, `div_rem`, original operands, |dividend|, |divisor| and sign flags; clear quotient/partial remainder; counter=0; go to CALC.
  - In unsigned mode the magnitudes are the raw operands.
- CALC:
  - One restoring step per cycle: shift remainder left by 1, bringing in the next dividend MSB.
  - Trial-subtract the divisor magnitude. If there is no borrow, keep the difference and set the quotient bit to 1; else the bit is 0.
  - After WIDTH steps (counter==WIDTH-1), go to DONE.
- DONE:
  - `ready`=1 and `result` valid; go to IDLE next cycle unconditionally.
  - The pipeline advances this cycle, so a `div_start` seen in the following IDLE cycle belongs to the next instruction.
- Sign correction, applied at the DONE output:
  - The quotient is negated when the signs differ.
  - The remainder takes the sign of the dividend.
- Divisor == 0:
  - quotient = all-ones; remainder = original dividend.
  - Sign correction is suppressed in both modes.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. The algorithm yields this naturally.
- Operand changes after the IDLE→CALC transition are ignored.
- `flush` in any state: next state IDLE, no `ready` pulse. `flush` has priority over `div_start`.
- `rst`: state IDLE; `result`=0, `ready`=0, internal registers 0. `stallreq_ex` follows `div_start` with ready=0.

## Timing
- Let `div_start` first be sampled in IDLE at cycle 0.
- CALC occupies cycles 1..WIDTH; DONE is cycle WIDTH+1 (33), where `ready`=1.
- `stallreq_ex`=1 for cycles 0..32 (33 cycles) and 0 at cycle 33.
- Back-to-back divides: the next op is sampled at cycle 34, so throughput is one op per 34 cycles.
- `result` is registered and held at its last value outside DONE. Consumers must qualify it with `ready`.

## Configuration
- `EX_DIV_FASTPATH_EN` defined:
  - In IDLE, a zero divisor or signed overflow goes directly to DONE with the special-case result.
  - `ready` comes at cycle 1; the stall lasts 1 cycle.
- Undefined: all ops take the full WIDTH+1 cycles. Results are identical either way.

## Structure
- Shared define header:
  - state encodings `DivIdle`/`DivCalc`/`DivDone`;
  - `DivWidth`=32;
  - `DivCntBus`.
  - The `StallBus` width stays where the controller already uses it.
- Sub-module `ex_div_step`: combinational single restoring iteration. Inputs: partial remainder, next dividend bit, divisor magnitude. Outputs: new remainder, quotient bit.

## Test plan
- DIVU 100/7, div_rem=0: `ready` at cycle 33, result 14; `stallreq_ex` high for exactly 33 cycles. REMU, same operands: 2.
- DIV -7/2, then REM -7/2: 0xFFFFFFFD (-3), then 0xFFFFFFFF (-1). DIV 7/-2: 0xFFFFFFFD.
- Divide by zero:
  - DIV -5/0 → 0xFFFFFFFF; REM -5/0 → 0xFFFFFFFB.
  - With `EX_DIV_FASTPATH_EN`, `ready` at cycle 1; without it, at cycle 33.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- `flush` at cycle 10 of a divide: IDLE at cycle 11, no `ready` pulse. A new DIVU 9/3 started at cycle 11 yields 3 with `ready` 33 cycles later (fastpath off).
- `rst` asserted at cycle 20 with `div_start` high: cycle 21 is IDLE, `result`=0, `ready`=0. Releasing `rst` restarts the divide from cycle 0.
